// File: rtl/decode_ctrl_stage_pkg.sv
// Shared decode definitions for the ID stage and the ALU control unit:
// opcode values, ALU operation codes, one-hot function codes, the bubble
// function code and the ID/EX register layout.
package decode_ctrl_stage_pkg;

    // Primary opcodes carried in instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_SUBI  = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b000110;
    localparam logic [5:0] OP_BEQ   = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b001000;

    // ALU operation codes; ALU_FUNC defers to the func field
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_FUNC = 3'b111;

    // One-hot R-type function codes
    localparam logic [6:0] FUNC_ADD = 7'b0000001;
    localparam logic [6:0] FUNC_SUB = 7'b0000010;
    localparam logic [6:0] FUNC_AND = 7'b0000100;
    localparam logic [6:0] FUNC_OR  = 7'b0001000;
    localparam logic [6:0] FUNC_SLT = 7'b0010000;
    localparam logic [6:0] FUNC_NOP = 7'b0100000;
    localparam logic [6:0] FUNC_SLL = 7'b1000000;

    // Function code carried by every non-R-type instruction and by bubbles
    localparam logic [6:0] FUNC_BUBBLE = FUNC_NOP;

    // Combinational decode result for one opcode
    typedef struct packed {
        logic [2:0] alu_op;
        logic [6:0] func;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic       uses_rt;
    } dec_t;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic       ex_valid;
        logic [2:0] alu_op;
        logic [6:0] func;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       jump;
        logic       illegal;
    } id_ex_t;

    // Bubble value of the ID/EX register, optionally flagged as illegal
    function automatic id_ex_t id_ex_bubble(input logic illegal);
        id_ex_t b;
        b          = '0;
        b.alu_op   = ALU_ADD;
        b.func     = FUNC_BUBBLE;
        b.illegal  = illegal;
        return b;
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// IF/ID inputs, stall/flush controls and the registered ID/EX outputs of
// the decode stage, grouped as one bus.
interface decode_ctrl_stage_if;
    logic        if_valid;
    logic [31:0] instr;
    logic        ex_stall;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [2:0]  alu_op;
    logic [6:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        jump;
    logic        illegal;

    // Pipeline side driving the decode stage
    modport master (
        output if_valid, instr, ex_stall, flush,
        input  id_stall, ex_valid, alu_op, func, rs, rt, rd,
        input  reg_write, mem_read, mem_write, alu_src, reg_dst,
        input  branch, jump, illegal
    );

    // Decode stage itself
    modport slave (
        input  if_valid, instr, ex_stall, flush,
        output id_stall, ex_valid, alu_op, func, rs, rt, rd,
        output reg_write, mem_read, mem_write, alu_src, reg_dst,
        output branch, jump, illegal
    );
endinterface

// File: rtl/decode_ctrl_stage_op_decoder.sv
// Combinational opcode decode table. Unknown opcodes raise illegal and
// leave every control bit clear.
module op_decoder
    import decode_ctrl_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [6:0] func_field,
    output dec_t       dec
);

    // Translate the opcode into ALU/memory/writeback control bits
    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.func   = FUNC_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                dec.alu_op    = ALU_FUNC;
                dec.func      = func_field;
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_SUBI: begin
                dec.alu_op    = ALU_SUB;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec.alu_op    = ALU_AND;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_ORI: begin
                dec.alu_op    = ALU_OR;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_SW: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec.alu_op    = ALU_SUB;
                dec.branch    = 1'b1;
                dec.uses_rt   = 1'b1;
            end
            OP_J: begin
                dec.alu_op    = ALU_ADD;
                dec.jump      = 1'b1;
            end
            default: begin
                dec.illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Instruction decode stage: decodes the IF/ID instruction, detects
// load-use hazards against the instruction in EX, and owns the ID/EX
// pipeline register with flush/stall/bubble handling.
module decode_ctrl_stage
    import decode_ctrl_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    decode_ctrl_stage_if.slave bus
);

    logic [5:0] opcode_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic [6:0] func_field_s;
    logic       unused_instr_s;
    dec_t       dec_s;
    logic       hazard_s;
    id_ex_t     id_ex_r;
    id_ex_t     id_ex_nxt_s;

    assign opcode_s       = bus.instr[31:26];
    assign rs_s           = bus.instr[25:21];
    assign rt_s           = bus.instr[20:16];
    assign rd_s           = bus.instr[15:11];
    assign func_field_s   = bus.instr[6:0];
    assign unused_instr_s = ^bus.instr[10:7];

    op_decoder u_op_decoder (
        .opcode     (opcode_s),
        .func_field (func_field_s),
        .dec        (dec_s)
    );

    // Load in EX whose destination feeds a source of the ID instruction
    always_comb begin
        hazard_s = 1'b0;
        if (id_ex_r.ex_valid && id_ex_r.mem_read && bus.if_valid &&
            (id_ex_r.rt != 5'd0)) begin
            hazard_s = (id_ex_r.rt == rs_s) ||
                       (dec_s.uses_rt && (id_ex_r.rt == rt_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // A flush cancels the hazard stall since the ID instruction is squashed
    assign bus.id_stall = bus.ex_stall | (hazard_s & ~bus.flush);

    // Next ID/EX contents: flush, then EX hold, then hazard bubble, then load
    always_comb begin
        id_ex_nxt_s = id_ex_r;
        if (bus.flush) begin
            id_ex_nxt_s = id_ex_bubble(1'b0);
        end else if (bus.ex_stall) begin
            id_ex_nxt_s = id_ex_r;
        end else if (hazard_s) begin
            id_ex_nxt_s = id_ex_bubble(1'b0);
        end else if (bus.if_valid) begin
            if (dec_s.illegal) begin
                id_ex_nxt_s = id_ex_bubble(1'b1);
            end else begin
                id_ex_nxt_s.ex_valid  = 1'b1;
                id_ex_nxt_s.alu_op    = dec_s.alu_op;
                id_ex_nxt_s.func      = dec_s.func;
                id_ex_nxt_s.rs        = rs_s;
                id_ex_nxt_s.rt        = rt_s;
                id_ex_nxt_s.rd        = rd_s;
                id_ex_nxt_s.reg_write = dec_s.reg_write;
                id_ex_nxt_s.mem_read  = dec_s.mem_read;
                id_ex_nxt_s.mem_write = dec_s.mem_write;
                id_ex_nxt_s.alu_src   = dec_s.alu_src;
                id_ex_nxt_s.reg_dst   = dec_s.reg_dst;
                id_ex_nxt_s.branch    = dec_s.branch;
                id_ex_nxt_s.jump      = dec_s.jump;
                id_ex_nxt_s.illegal   = 1'b0;
            end
        end else begin
            id_ex_nxt_s = id_ex_bubble(1'b0);
        end
    end

    // ID/EX register; reset drops any held instruction at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_r <= id_ex_bubble(1'b0);
        end else begin
            id_ex_r <= id_ex_nxt_s;
        end
    end

    assign bus.ex_valid  = id_ex_r.ex_valid;
    assign bus.alu_op    = id_ex_r.alu_op;
    assign bus.func      = id_ex_r.func;
    assign bus.rs        = id_ex_r.rs;
    assign bus.rt        = id_ex_r.rt;
    assign bus.rd        = id_ex_r.rd;
    assign bus.reg_write = id_ex_r.reg_write;
    assign bus.mem_read  = id_ex_r.mem_read;
    assign bus.mem_write = id_ex_r.mem_write;
    assign bus.alu_src   = id_ex_r.alu_src;
    assign bus.reg_dst   = id_ex_r.reg_dst;
    assign bus.branch    = id_ex_r.branch;
    assign bus.jump      = id_ex_r.jump;
    assign bus.illegal   = id_ex_r.illegal;

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL expose ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL expose: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: if_valid  in  1  IF/ID holds a valid instruction.
REQ-004 SHALL expose: instr  in  32  fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], func[6:0].
REQ-005 SHALL expose: ex_stall  in  1  EX stage cannot accept; hold ID/EX.
REQ-006 SHALL expose: flush  in  1  taken branch/jump; squash the ID instruction.
REQ-007 SHALL expose: id_stall  out  1  combinational; IF/ID and PC hold when high.
REQ-008 SHALL expose registered ID/EX outputs: ex_valid 1, alu_op 3, func 7, rs 5, rt 5, rd 5, reg_write 1, mem_read 1, mem_write 1, alu_src 1, reg_dst 1, branch 1, jump 1, illegal 1.

Function
REQ-009 Decode table SHALL be: opcode 000000 R-type: alu_op 111, reg_write, reg_dst.
REQ-010 Opcodes 000001 addi, 000010 subi, 000011 andi, 000100 ori SHALL give alu_op 000/001/010/011, alu_src, reg_write.
REQ-011 Opcode 000101 lw SHALL give alu_op 000, alu_src, mem_read, reg_write; 000110 sw SHALL give alu_op 000, alu_src, mem_write.
REQ-012 Opcode 000111 beq SHALL give alu_op 001, branch; 001000 j SHALL give jump, alu_op 000.
REQ-013 Any other opcode SHALL load a bubble with illegal=1 (ex_valid=0).
REQ-014 func SHALL pass instr[6:0] for R-type, else 7'b0100000 (nop); rs/rt/rd SHALL pass instr fields unchanged.
REQ-015 Bubble SHALL be: ex_valid 0, all control bits 0, alu_op 000, func 7'b0100000, rs/rt/rd 0.
REQ-016 Load-use hazard SHALL be: ex_valid && mem_read && if_valid && ex rt != 0 && (ex rt == instr rs || (instr uses rt && ex rt == instr rt)); R-type, sw, beq use rt.
REQ-017 id_stall SHALL equal ex_stall OR (load-use hazard AND NOT flush).
REQ-018 Next-state priority SHALL be: flush -> bubble; else ex_stall -> hold all registers; else hazard -> bubble; else if_valid -> decoded instr; else bubble.
REQ-019 flush SHALL override ex_stall (squash wins even when EX holds).
REQ-020 Latency SHALL be one cycle: instr sampled at edge N appears on outputs after edge N.
REQ-021 Load-use stall SHALL last exactly one cycle, because the inserted bubble clears the hazard condition.
REQ-022 illegal SHALL be registered with the bubble and SHALL clear on the next non-held load.

Reset
REQ-023 rst high SHALL immediately force all registered outputs to the bubble value of REQ-015, with illegal=0.
REQ-024 Reset mid-stall SHALL drop any held instruction; first post-reset edge SHALL load normally per REQ-018.

Structure
REQ-025 Opcode constants, alu_op codes (000,001,010,011,111), one-hot func codes and the bubble func SHALL live in a shared package used by this block and the ALU control unit.
REQ-026 The combinational decode table SHALL be one sub-module, op_decoder; hazard detection and the ID/EX register stay in decode_ctrl_stage.

Verification
REQ-027 Bench SHALL drive R-type instr with func 0000010 and if_valid=1 -> next cycle ex_valid=1, alu_op=111, func=0000010, reg_write=1, reg_dst=1.
REQ-028 Bench SHALL send lw rt=5 then add with rs=5 -> id_stall=1 for one cycle, bubble in EX, add decoded the following cycle.
REQ-029 Bench SHALL send lw rt=0 then add with rs=0 -> no stall.
REQ-030 Bench SHALL hold ex_stall=1 for 3 cycles with a new instr -> outputs unchanged and id_stall=1 throughout; flush=1 during the stall -> bubble next cycle.
REQ-031 Bench SHALL send opcode 111111 -> next cycle ex_valid=0, illegal=1; a following valid ori -> illegal=0, alu_op=011.
REQ-032 Bench SHALL assert rst mid-cycle while ex_valid=1 -> outputs bubble immediately, without waiting for clk.
